instr_fetch: RTL and testbench

Instruction-fetch stage of the 9-bit accumulator-style core. It holds the program counter, a writable instruction memory and a 16-entry branch-target lookup table. Every cycle it presents the current instruction to the control decoder and the datapath, then picks the next PC from the decoder's `Branch`/`Jump` outputs and the ALU zero flag. A small run-control FSM handles program load, `Start`, and completion (`Done`).

---
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: program counter, writable instruction memory, branch-target LUT
// and the IDLE/RUN/DONE run-control FSM.
module instr_fetch #(
  parameter int unsigned PW = 10,
  parameter int unsigned IW = 9,
  parameter int unsigned LW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW-1:0] ProgLen,
  input  logic          ImWe,
  input  logic [PW-1:0] ImAddr,
  input  logic [IW-1:0] ImData,
  input  logic          LutWe,
  input  logic [LW-1:0] LutIdx,
  input  logic [PW-1:0] LutData,
  input  logic          Stall,
  input  logic          Branch,
  input  logic          Zero,
  input  logic          Jump,
  input  logic [PW-1:0] JumpTarget,
  output logic [IW-1:0] Instr,
  output logic          InstrValid,
  output logic [PW-1:0] PC,
  output logic [PW-1:0] LinkAddr,
  output logic          Running,
  output logic          Done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;

  logic [IW-1:0] imem [2**PW];
  logic [PW-1:0] lut  [2**LW];

  logic          load_ok;
  logic          at_end;
  logic [LW-1:0] lut_idx;

  // Memory/LUT loading is only legal while the core is not executing.
  assign load_ok  = (state_q != StRun);
  assign at_end   = (pc_q >= ProgLen);
  assign lut_idx  = Instr[LW+1:2];

  assign Instr      = imem[pc_q];
  assign PC         = pc_q;
  assign LinkAddr   = pc_q + PW'(1);
  assign Running    = (state_q == StRun);
  assign Done       = (state_q == StDone);
  assign InstrValid = (state_q == StRun) && !at_end;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        if (at_end) begin
          state_d = StDone;
        end else if (!Stall) begin
          if (Jump) begin
            pc_d = JumpTarget;
          end else if (Branch && Zero) begin
            pc_d = lut[lut_idx];
          end else begin
            pc_d = LinkAddr;
          end
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Storage is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge Clk) begin
    if (ImWe && load_ok) begin
      imem[ImAddr] <= ImData;
    end
  end

  always_ff @(posedge Clk) begin
    if (LutWe && load_ok) begin
      lut[LutIdx] <= LutData;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch, checked each cycle against an
// array-based behavioural model of the fetch stage.
module tb_instr_fetch;
  localparam int PW    = 10;
  localparam int IW    = 9;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << PW;

  logic          Clk = 1'b0;
  logic          Reset, Start, ImWe, LutWe, Stall, Branch, Zero, Jump;
  logic [PW-1:0] ProgLen, ImAddr, LutData, JumpTarget;
  logic [IW-1:0] ImData;
  logic [LW-1:0] LutIdx;
  logic [IW-1:0] Instr;
  logic          InstrValid, Running, Done;
  logic [PW-1:0] PC, LinkAddr;

  instr_fetch #(.PW(PW), .IW(IW), .LW(LW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgLen(ProgLen),
    .ImWe(ImWe), .ImAddr(ImAddr), .ImData(ImData),
    .LutWe(LutWe), .LutIdx(LutIdx), .LutData(LutData),
    .Stall(Stall), .Branch(Branch), .Zero(Zero), .Jump(Jump), .JumpTarget(JumpTarget),
    .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .LinkAddr(LinkAddr),
    .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Model: 0 = idle, 1 = run, 2 = done
  int m_state, m_pc;
  int m_imem [DEPTH];
  int m_lut  [16];
  int total, bad;
  bit cmp_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("pc", 32'(PC), 32'(m_pc));
    chk("running", 32'(Running), 32'(m_state == 1));
    chk("done", 32'(Done), 32'(m_state == 2));
    chk("valid", 32'(InstrValid), 32'(m_state == 1 && m_pc < int'(ProgLen)));
    chk("link", 32'(LinkAddr), 32'((m_pc + 1) % DEPTH));
    chk("instr", 32'(Instr), 32'(m_imem[m_pc]));
  endtask

  task automatic idle_inputs();
    Start = 0; ImWe = 0; LutWe = 0; Stall = 0; Branch = 0; Zero = 0; Jump = 0;
    ImAddr = '0; ImData = '0; LutIdx = '0; LutData = '0; JumpTarget = '0;
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic clk_step();
    int ns, np;
    @(negedge Clk);
    if (cmp_on) compare();
    ns = m_state;
    np = m_pc;
    if (Reset) begin
      ns = 0;
      np = 0;
    end else if (m_state != 1) begin
      if (Start) begin
        ns = 1;
        np = 0;
      end
    end else if (m_pc >= int'(ProgLen)) begin
      ns = 2;
    end else if (Stall) begin
      np = m_pc;
    end else if (Jump) begin
      np = int'(JumpTarget);
    end else if (Branch && Zero) begin
      np = m_lut[(m_imem[m_pc] >> 2) & 15];
    end else begin
      np = (m_pc + 1) % DEPTH;
    end
    @(posedge Clk);
    if (m_state != 1 && !Reset) begin
      if (ImWe) m_imem[int'(ImAddr)] = int'(ImData);
      if (LutWe) m_lut[int'(LutIdx)] = int'(LutData);
    end
    m_state = ns;
    m_pc = np;
    #1;
  endtask

  task automatic do_reset();
    Reset = 1;
    #1;
    m_state = 0;
    m_pc = 0;
    if (cmp_on) compare();
    clk_step();
    Reset = 0;
  endtask

  task automatic wr_imem(input int a, input int d);
    ImWe = 1; ImAddr = PW'(a); ImData = IW'(d);
    clk_step();
    ImWe = 0;
  endtask

  task automatic wr_lut(input int i, input int d);
    LutWe = 1; LutIdx = LW'(i); LutData = PW'(d);
    clk_step();
    LutWe = 0;
  endtask

  task automatic restart(input int plen);
    do_reset();
    ProgLen = PW'(plen);
    Start = 1;
    clk_step();
    Start = 0;
  endtask

  task automatic jump_to(input int t);
    Jump = 1; JumpTarget = PW'(t);
    clk_step();
    Jump = 0;
  endtask

  initial begin
    total = 0; bad = 0; cmp_on = 0;
    idle_inputs();
    ProgLen = '0;
    Reset = 1;
    #1;
    m_state = 0; m_pc = 0;
    chk("rst_pc", 32'(PC), 0);
    chk("rst_running", 32'(Running), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_valid", 32'(InstrValid), 0);
    chk("rst_link", 32'(LinkAddr), 1);
    clk_step();
    Reset = 0;

    for (int a = 0; a < DEPTH; a++) wr_imem(a, int'($urandom_range(0, 511)));
    for (int i = 0; i < 16; i++) wr_lut(i, int'($urandom_range(0, 63)));
    cmp_on = 1;

    // Straight-line program of four instructions
    ProgLen = 4;
    Start = 1;
    clk_step();
    Start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", 32'(PC), 32'(i));
      chk("seq_valid", 32'(InstrValid), 1);
      clk_step();
    end
    chk("end_pc", 32'(PC), 4);
    chk("end_valid", 32'(InstrValid), 0);
    chk("end_notdone", 32'(Done), 0);
    clk_step();
    chk("done_set", 32'(Done), 1);
    chk("done_pc", 32'(PC), 4);
    clk_step();
    chk("done_hold", 32'(Done), 1);

    // Branch taken / not taken through lut[5]
    wr_imem(2, 9'b001_0101_00);
    wr_lut(5, 10'h020);
    for (int z = 1; z >= 0; z--) begin
      restart(64);
      clk_step();
      clk_step();
      chk("br_at2", 32'(PC), 2);
      Branch = 1; Zero = z[0];
      clk_step();
      Branch = 0; Zero = 0;
      chk("br_target", 32'(PC), (z == 1) ? 32'h020 : 32'd3);
    end

    // Jump beats a simultaneous taken branch
    restart(10'h200);
    jump_to(7);
    Jump = 1; JumpTarget = 10'h100; Branch = 1; Zero = 1;
    #1;
    chk("jal_link", 32'(LinkAddr), 8);
    clk_step();
    idle_inputs();
    chk("jal_pc", 32'(PC), 32'h100);

    // Stall masks a jump
    restart(64);
    jump_to(5);
    Stall = 1; Jump = 1; JumpTarget = 10'h033;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      chk("stall_pc", 32'(PC), 5);
    end
    idle_inputs();
    clk_step();
    chk("unstall_pc", 32'(PC), 6);

    // Writes during RUN are dropped; reset mid-run
    do_reset();
    wr_imem(4, 9'h0AA);
    ProgLen = 64;
    Start = 1;
    clk_step();
    Start = 0;
    jump_to(3);
    ImWe = 1; ImAddr = 4; ImData = 9'h155;
    clk_step();
    ImWe = 0;
    chk("run_wr_dropped", 32'(Instr), 32'h0AA);
    jump_to(3);
    Reset = 1;
    #1;
    m_state = 0; m_pc = 0;
    chk("midrst_pc", 32'(PC), 0);
    chk("midrst_running", 32'(Running), 0);
    clk_step();
    Reset = 0;
    clk_step();
    clk_step();
    chk("midrst_done", 32'(Done), 0);
    chk("midrst_idle", 32'(Running), 0);

    // LinkAddr wraps at the top of the address space
    restart(10'h3FF);
    jump_to(10'h3FF);
    chk("wrap_link", 32'(LinkAddr), 0);
    chk("wrap_valid", 32'(InstrValid), 0);
    clk_step();
    chk("wrap_done", 32'(Done), 1);

    // Empty program
    restart(0);
    chk("empty_valid", 32'(InstrValid), 0);
    chk("empty_run", 32'(Running), 1);
    clk_step();
    chk("empty_done", 32'(Done), 1);

    // Randomized programs
    for (int p = 0; p < 40; p++) begin
      for (int w = 0; w < 6; w++) begin
        if ($urandom_range(0, 1) == 1) wr_imem(int'($urandom_range(0, 63)), int'($urandom_range(0, 511)));
        else wr_lut(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
      end
      ProgLen = PW'($urandom_range(0, 48));
      Start = 1;
      ImWe = $urandom_range(0, 1) == 1;
      ImAddr = PW'($urandom_range(0, 63));
      ImData = IW'($urandom);
      clk_step();
      ImWe = 0;
      for (int c = 0; c < 200 && m_state != 2; c++) begin
        Start      = $urandom_range(0, 9) == 0;
        Stall      = $urandom_range(0, 3) == 0;
        Jump       = $urandom_range(0, 9) == 0;
        JumpTarget = PW'($urandom_range(0, 63));
        Branch     = $urandom_range(0, 3) == 0;
        Zero       = $urandom_range(0, 1) == 1;
        ImWe       = $urandom_range(0, 7) == 0;
        ImAddr     = PW'($urandom_range(0, 63));
        ImData     = IW'($urandom);
        LutWe      = $urandom_range(0, 7) == 0;
        LutIdx     = LW'($urandom);
        LutData    = PW'($urandom);
        if ($urandom_range(0, 99) == 0) begin
          idle_inputs();
          do_reset();
          break;
        end
        clk_step();
      end
      idle_inputs();
      clk_step();
      if ($urandom_range(0, 3) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
